dcache_miss_ctrl: RTL and testbench

//  Controller for the pipeline's direct-mapped data cache: tag/valid/dirty lookup, write-back/write-allocate policy, miss sequencing to main memory.

---
 rtl/dcache_miss_ctrl_pkg.sv | 24 ++
 rtl/dcache_miss_ctrl_if.sv | 30 +++
 rtl/dcache_tag_array.sv | 65 ++++++
 rtl/dcache_miss_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared definitions for the direct-mapped data-cache miss controller:
// FSM state encoding, default geometry and the tag-width/line-count helpers.
package dcache_miss_ctrl_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int INDEX_BITS_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_e;

  // Byte address = {tag, index, 2'b00}; one word per line.
  function automatic int tag_w(input int addr_w, input int index_bits);
    return addr_w - index_bits - 2;
  endfunction

  function automatic int lines(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// MEM-stage request/response and external memory port of the data cache.
// slave = cache controller side, master = pipeline/memory environment side.
interface dcache_miss_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_tag_array.sv
// Line storage for the direct-mapped cache: valid/dirty/tag/data per line,
// asynchronous read, synchronous whole-line write, async clear of valid/dirty.
module dcache_tag_array
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_W      = tag_w(ADDR_W_DEF, INDEX_BITS_DEF),
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);
  localparam int LINES = lines(INDEX_BITS);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // NOTE: defaults assigned first so the write-enable path cannot infer a latch.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_valid;
      dirty_d[wr_idx] = wr_dirty;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag/data are not reset; valid gates every use, so they map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped write-back/write-allocate data-cache controller with miss FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  dcache_miss_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_BITS);

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:2]   miss_addr_q, miss_addr_d;

  logic [INDEX_BITS-1:0] cpu_idx, miss_idx, rd_idx;
  logic [TAG_W-1:0]      cpu_tag, miss_tag;
  logic                  rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]      wr_tag;
  logic [DATA_W-1:0]     wr_data;
  logic                  stall;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  unused_addr_lsb;

  assign cpu_idx  = bus.cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag  = bus.cpu_addr[ADDR_W-1:INDEX_BITS+2];
  assign miss_idx = miss_addr_q[INDEX_BITS+1:2];
  assign miss_tag = miss_addr_q[ADDR_W-1:INDEX_BITS+2];
  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  // While a miss is in flight the array is addressed by the latched miss line.
  assign rd_idx = (state_q == S_IDLE) ? cpu_idx : miss_idx;
  assign hit    = rd_valid && (rd_tag == cpu_tag);

  dcache_tag_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (DATA_W)
  ) u_tag_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (rd_idx),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_addr_d = miss_addr_q;
    wr_en       = 1'b0;
    wr_valid    = rd_valid;
    wr_dirty    = rd_dirty;
    wr_tag      = rd_tag;
    wr_data     = rd_data;
    stall       = 1'b0;
    cpu_rdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          if (hit) begin
            if (bus.cpu_we) begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
              wr_data  = bus.cpu_wdata;
            end else begin
              cpu_rdata = rd_data;
            end
          end else begin
            stall       = 1'b1;
            miss_addr_d = bus.cpu_addr[ADDR_W-1:2];
            mem_req_d   = 1'b1;
            if (rd_valid && rd_dirty) begin
              state_d     = S_WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {rd_tag, cpu_idx, 2'b00};
              mem_wdata_d = rd_data;
            end else begin
              state_d     = S_REFILL;
              mem_we_d    = 1'b0;
              mem_addr_d  = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
              mem_wdata_d = '0;
            end
          end
        end
      end
      S_WRITEBACK: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          wr_en       = 1'b1;
          wr_dirty    = 1'b0;
          state_d     = S_REFILL;
          mem_we_d    = 1'b0;
          mem_addr_d  = {miss_addr_q, 2'b00};
          mem_wdata_d = '0;
        end
      end
      S_REFILL: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          wr_en       = 1'b1;
          wr_valid    = 1'b1;
          wr_dirty    = 1'b0;
          wr_tag      = miss_tag;
          wr_data     = bus.mem_rdata;
          state_d     = S_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE && bus.cpu_req) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed self-checking bench for dcache_miss_ctrl with a latency-programmable
// memory model that logs every completed memory transaction.
module tb_dcache_miss_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_miss_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_miss_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: acks mem_latency cycles into each request and logs it.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  int          mem_latency = 3;
  int          mem_cnt     = 0;
  logic        model_ack   = 1'b0;
  logic        force_ack   = 1'b0;
  logic [31:0] model_rdata = '0;

  assign bus.mem_ack   = model_ack | force_ack;
  assign bus.mem_rdata = model_rdata;

  always @(negedge clk) begin
    model_ack = 1'b0;
    if (bus.mem_req === 1'b1) begin
      mem_cnt++;
      if (mem_cnt >= mem_latency) begin
        model_ack = 1'b1;
        mem_cnt   = 0;
        log_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
        if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
        else model_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 32'h0;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // One CPU access: hold the request until stall drops, return stall count and load data.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    stalls = 0;
    #1;
    while (bus.stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("stall_bound", {31'b0, bus.stall}, 32'd0);
    rdata = bus.cpu_rdata;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int idx, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t = (idx < log_q.size()) ? log_q[idx] : '{1'bx, 32'hx, 32'hx};
    check({tag, "_we"}, {31'b0, t.we}, {31'b0, we});
    check({tag, "_addr"}, t.addr, addr);
    if (we) check({tag, "_wdata"}, t.wdata, wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          st;
    logic [31:0] rd;

    mem_arr[32'h10] = 32'hDEAD_BEEF;
    mem_arr[32'h50] = 32'hCAFE_0050;
    mem_arr[32'h24] = 32'h1111_2222;
    mem_arr[32'h64] = 32'h6464_6464;
    mem_arr[32'h38] = 32'h3838_3838;

    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    #1;
    check("rst_stall",     {31'b0, bus.stall},   32'd0);
    check("rst_mem_req",   {31'b0, bus.mem_req}, 32'd0);
    check("rst_mem_we",    {31'b0, bus.mem_we},  32'd0);
    check("rst_mem_addr",  bus.mem_addr,         32'd0);
    check("rst_mem_wdata", bus.mem_wdata,        32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata,        32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Cold load: 1 lookup cycle + 3 memory cycles.
    access(1'b0, 32'h10, '0, st, rd);
    check("cold_stalls", st, 32'd4);
    check("cold_rdata", rd, 32'hDEAD_BEEF);
    check("cold_ntxn", log_q.size(), 32'd1);
    check_txn("cold_txn", 0, 1'b0, 32'h10, '0);

    access(1'b0, 32'h10, '0, st, rd);
    check("hit_stalls", st, 32'd0);
    check("hit_rdata", rd, 32'hDEAD_BEEF);
    check("hit_ntxn", log_q.size(), 32'd1);

    // Dirty victim: write-back of the store, then refill of the new tag.
    access(1'b1, 32'h10, 32'h1234, st, rd);
    check("st_hit_stalls", st, 32'd0);
    access(1'b0, 32'h50, '0, st, rd);
    check("dirty_stalls", st, 32'd7);
    check("dirty_rdata", rd, 32'hCAFE_0050);
    check("dirty_ntxn", log_q.size(), 32'd3);
    check_txn("wb_txn", 1, 1'b1, 32'h10, 32'h1234);
    check_txn("rf_txn", 2, 1'b0, 32'h50, '0);

    // Refilled line is clean: evicting it again needs no write-back.
    access(1'b0, 32'h10, '0, st, rd);
    check("clean_stalls", st, 32'd4);
    check("clean_rdata", rd, 32'h1234);
    check_txn("clean_txn", 3, 1'b0, 32'h10, '0);

    // Store miss: write-allocate, then the line holds the store and is dirty.
    access(1'b1, 32'h24, 32'h5555_AAAA, st, rd);
    check("stmiss_stalls", st, 32'd4);
    check_txn("stmiss_txn", 4, 1'b0, 32'h24, '0);
    access(1'b0, 32'h24, '0, st, rd);
    check("stmiss_hit_stalls", st, 32'd0);
    check("stmiss_rdata", rd, 32'h5555_AAAA);
    access(1'b0, 32'h64, '0, st, rd);
    check("stmiss_evict_stalls", st, 32'd7);
    check("stmiss_evict_rdata", rd, 32'h6464_6464);
    check_txn("stmiss_wb", 5, 1'b1, 32'h24, 32'h5555_AAAA);
    check_txn("stmiss_rf", 6, 1'b0, 32'h64, '0);

    // Reset in the middle of a refill, then a stale ack.
    mem_latency = 1000;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h38;
    repeat (2) @(negedge clk);
    #1;
    check("mid_mem_req",  {31'b0, bus.mem_req}, 32'd1);
    check("mid_mem_we",   {31'b0, bus.mem_we},  32'd0);
    check("mid_mem_addr", bus.mem_addr,         32'h38);
    check("mid_stall",    {31'b0, bus.stall},   32'd1);
    reset       = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    check("arst_stall",    {31'b0, bus.stall},   32'd0);
    check("arst_mem_req",  {31'b0, bus.mem_req}, 32'd0);
    check("arst_mem_addr", bus.mem_addr,         32'd0);
    @(negedge clk);
    reset       = 1'b1;
    mem_latency = 3;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    #1;
    check("stale_mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("stale_stall",   {31'b0, bus.stall},   32'd0);
    check("stale_ntxn", log_q.size(), 32'd7);
    access(1'b0, 32'h38, '0, st, rd);
    check("after_rst_38_stalls", st, 32'd4);
    check("after_rst_38_rdata", rd, 32'h3838_3838);
    access(1'b0, 32'h10, '0, st, rd);
    check("after_rst_10_stalls", st, 32'd4);
    check("after_rst_10_rdata", rd, 32'h1234);
    check_txn("after_rst_txn", 8, 1'b0, 32'h10, '0);

`ifdef DCACHE_STATS_EN
    // Each miss also produces one hit cycle when the held request retries.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("stats_rst_hits", hit_count, 32'd0);
    access(1'b0, 32'h10, '0, st, rd);
    access(1'b0, 32'h10, '0, st, rd);
    access(1'b0, 32'h24, '0, st, rd);
    access(1'b0, 32'h24, '0, st, rd);
    #1;
    check("stats_hits", hit_count, 32'd4);
    check("stats_misses", miss_count, 32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
